// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and helpers for the programmable pattern detector.
//   state_t    - detector FSM state encoding (IDLE / FILL / ARMED)
//   calc_len_w - width needed to hold a pattern length of 0..pat_w
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    function automatic int calc_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// seq_match_cnt: saturating event counter with synchronous clear.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - zero the counter (wins over inc)
//   inc        - count one event
//   cnt        - current count, sticks at all-ones
module seq_match_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial bit-pattern detector.
// Pulses result one cycle after the last len accepted bits equal pat[len-1:0]
// (bit len-1 is the oldest bit, bit 0 the newest).
//   clk, rst_n        - clock, asynchronous active-low reset
//   cfg_wr            - load cfg_pat / cfg_len / cfg_ovl (drops a coincident bit)
//   cfg_pat, cfg_len  - pattern and its length (1..PAT_W valid, else IDLE)
//   cfg_ovl           - 1: overlapping matches allowed
//   din_vld, din      - qualified serial input
//   result            - registered one-cycle match pulse
//   armed             - high while the next accepted bit can complete a match
// Optional feature, macro SEQ_DET_MATCH_CNT_EN:
//   clr_cnt           - clear match counter
//   match_cnt         - saturating count of matches
//
// state | meaning
// IDLE  | configuration invalid, input bits ignored
// FILL  | fewer than len-1 bits collected since (re)start
// ARMED | next accepted bit is compared against the pattern
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'b0001_0110),
    parameter int               DEF_LEN = 5,
    parameter logic             DEF_OVL = 1'b1,
`ifdef SEQ_DET_MATCH_CNT_EN
    parameter int               CNT_W   = 16,
`endif
    localparam int              LEN_W   = calc_len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_wr,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             din_vld,
    input  logic             din,
`ifdef SEQ_DET_MATCH_CNT_EN
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             result,
    output logic             armed
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    state_t           state;
    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] fcnt;
    logic             ovl;

    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] len_mask;
    logic             cfg_ok;
    logic             bit_acc;
    logic             match_hit;

    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], din};
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (LEN_W'(i) < len);
        end
        cfg_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN);
        bit_acc   = din_vld && !cfg_wr;
        match_hit = bit_acc && (state == ARMED) &&
                    ((hist_nxt & len_mask) == (pat & len_mask));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= (DEF_LEN == 1) ? ARMED : FILL;
            hist   <= '0;
            pat    <= DEF_PAT;
            len    <= LEN_W'(DEF_LEN);
            ovl    <= DEF_OVL;
            fcnt   <= '0;
            result <= 1'b0;
        end else begin
            result <= 1'b0;
            if (cfg_wr) begin
                hist <= '0;
                fcnt <= '0;
                if (cfg_ok) begin
                    pat   <= cfg_pat;
                    len   <= cfg_len;
                    ovl   <= cfg_ovl;
                    state <= (cfg_len == ONE_LEN) ? ARMED : FILL;
                end else begin
                    state <= IDLE;
                end
            end else if (din_vld) begin
                case (state)
                    FILL: begin
                        hist <= hist_nxt;
                        fcnt <= fcnt + 1'b1;
                        if ((fcnt + 1'b1) == (len - 1'b1)) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        hist <= hist_nxt;
                        if (match_hit) begin
                            result <= 1'b1;
                            // Non-overlap restarts collection; a 1-bit pattern
                            // has nothing to collect, so it stays armed.
                            if (!ovl && (len != ONE_LEN)) begin
                                fcnt  <= '0;
                                state <= FILL;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign armed = (state == ARMED);

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (match_hit),
        .cnt   (match_cnt)
    );
`endif

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Runtime-programmable serial bit-pattern detector, the parametrised successor of the team's fixed-pattern `seq_detector`. It consumes a qualified 1-bit stream (`din`/`din_vld`) and pulses `result` when the last `len` accepted bits equal a loadable pattern. Pattern, length and overlap mode are programmable. Out of reset it behaves as a fixed detector using parameter defaults. It sits between the serial input front-end and downstream event logic.

## Interface
Parameters:
- `PAT_W`, 8: maximum pattern length in bits.
- `DEF_PAT`, 8'b0001_0110: pattern loaded at reset (LSB-aligned).
- `DEF_LEN`, 5: length loaded at reset, 1..`PAT_W`.
- `DEF_OVL`, 1: overlap mode loaded at reset.
- `CNT_W`, 16: match counter width (macro-dependent).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cfg_wr`  in  1  load `cfg_pat`/`cfg_len`/`cfg_ovl` this cycle.
- `cfg_pat`  in  `PAT_W`  pattern; bit `cfg_len-1` is the first bit received, bit 0 the last.
- `cfg_len`  in  `LEN_W`=$clog2(`PAT_W`+1)  effective length.
- `cfg_ovl`  in  1  1 = overlapping matches allowed.
- `din_vld`  in  1  qualifies `din`.
- `din`  in  1  serial data bit.
- `result`  out  1  one-cycle match pulse.
- `armed`  out  1  high in state ARMED.
- `clr_cnt`, `match_cnt`: see Configuration.

## Operation
- Registers: history `hist[PAT_W-1:0]` (newest bit at LSB), fill count `fcnt` (saturates at `len-1`), `pat`, `len`, `ovl`, state.
- States:
  - IDLE: configuration invalid; bits ignored.
  - FILL: `fcnt < len-1`.
  - ARMED: the next accepted bit can complete a match.
- Accepted bit (`din_vld`=1, no `cfg_wr`): `hist <= {hist[PAT_W-2:0], din}`.
  - FILL: `fcnt`+1; go to ARMED when it reaches `len-1`.
  - ARMED: match = new `hist[len-1:0]` == `pat[len-1:0]` (bits at and above `len` ignored).
- On match:
  - `result` is 1 next cycle.
  - `ovl`=1: stay ARMED.
  - `ovl`=0: `fcnt`<=0 and go to FILL; if `len`=1, stay ARMED.
- `din_vld`=0: history, `fcnt` and state held; `result` 0.
- `cfg_wr`:
  - `cfg_len` in 1..`PAT_W`: latch config, clear `hist` and `fcnt`, then FILL (ARMED if `cfg_len`=1).
  - `cfg_len` 0 or >`PAT_W`: go to IDLE; old config discarded.
  - `cfg_wr` wins over a simultaneous `din_vld`; that bit is dropped.
- From IDLE, only a valid `cfg_wr` exits.

## Timing
- Reset: `result`=0, `armed`=0 (or 1 if `DEF_LEN`=1), `hist`=0, `fcnt`=0, `match_cnt`=0, state FILL with defaults loaded.
- Latency: bit sampled at edge N gives `result` high for cycle N..N+1, registered. Zero-latency combinational result is not permitted.
- Back-to-back `din_vld` with `ovl`=1 and `len`=1 can give a continuous `result`; each high cycle is one match.
- New config takes effect for bits sampled on the edge after the `cfg_wr` edge.
- Asserting `rst_n` mid-stream discards partial history immediately; any pending `result` is cleared.

## Configuration
- Macro: `SEQ_DET_MATCH_CNT_EN`.
- Defined:
  - Adds input `clr_cnt` (1) and output `match_cnt` (`CNT_W`).
  - `match_cnt` increments once per match and saturates at all-ones, never wrapping.
  - `clr_cnt` zeroes it; a simultaneous match is not counted.
  - `cfg_wr` does not clear it.
- Undefined: neither port exists, and no counter logic is present.

## Structure
- Package `seq_det_pkg`: state enum (IDLE/FILL/ARMED) and a `LEN_W` calc function.
- Sub-module `seq_match_cnt`: saturating counter with clear; instantiated only under the macro.

## Test plan
- Reset defaults (10110, `ovl`=1), stream 1,0,1,1,0,1,1,0 with `din_vld`=1: `result` high after bits 5 and 8. `match_cnt`=2.
- `cfg_wr` pat=10110, len=5, ovl=0, same stream: one pulse after bit 5 only.
- `din_vld` low for 3 cycles in the middle of 1,0,1 | 1,0: match still fires after bit 5. `result`=0 during the gap.
- `cfg_wr` same cycle as the completing bit: no pulse; `hist` cleared; the next 5 bits 10110 give a pulse.
- `cfg_len`=0: `armed`=0, 20 bits give no pulse. Then `cfg_wr` len=1 pat=1, stream 1,1,0,1: pulses on bits 1, 2 and 4.
- With the macro, `CNT_W`=2: 5 matches give `match_cnt`=3 (saturated). `clr_cnt` gives 0.
